// File: rtl/land_clear_unit_if.sv
// land_clear_unit_if: handshake, piece and display-read bundle between main_FSM and land_clear_unit.
// Ports (signals): start_land/start_clear level requests; piece_mask/x/y piece placement;
// which_row, land_done, clear_done, busy, game_over, lines_cleared status; rd_row/rd_data display read.
interface land_clear_unit_if #(parameter int COLS = 8);
  logic            start_land;
  logic            start_clear;
  logic [15:0]     piece_mask;
  logic [2:0]      piece_x;
  logic [3:0]      piece_y;
  logic [3:0]      which_row;
  logic            land_done;
  logic            clear_done;
  logic            busy;
  logic            game_over;
  logic [3:0]      rd_row;
  logic [COLS-1:0] rd_data;
  logic [7:0]      lines_cleared;
  modport master (
    output start_land, start_clear, piece_mask, piece_x, piece_y, rd_row,
    input  which_row, land_done, clear_done, busy, game_over, rd_data, lines_cleared
  );
  modport slave (
    input  start_land, start_clear, piece_mask, piece_x, piece_y, rd_row,
    output which_row, land_done, clear_done, busy, game_over, rd_data, lines_cleared
  );
endinterface

// File: rtl/land_clear_unit.sv
// land_clear_unit: owns the board bitmap, merges landed pieces, finds and removes full rows.
// Ports: clka (rising-edge clock), restart (async active-high reset), bus (land_clear_unit_if.slave:
// start_land/start_clear rising-edge launches, piece_mask/x/y, which_row, land_done, clear_done,
// busy, game_over, rd_row/rd_data registered display read, lines_cleared).
// Optional: define LINE_COUNT_EN for a saturating cleared-line counter; otherwise lines_cleared = 0.
module land_clear_unit #(
  parameter int ROWS = 11,
  parameter int COLS = 8
) (
  input logic             clka,
  input logic             restart,
  land_clear_unit_if.slave bus
);
  localparam logic [3:0] NONE = 4'b1011;
  typedef enum logic [2:0] {IDLE, MERGE, SCAN, SHIFT, LDONE, CDONE} state_t;
  state_t          state_q;
  logic            land_prev_q, clear_prev_q, clearing_q, found_q;
  logic            land_done_q, clear_done_q, busy_q, game_over_q;
  logic [3:0]      which_row_q, scan_q, k_q, found_row_q;
  logic [COLS-1:0] rd_data_q;
  logic [COLS-1:0] board_q [ROWS];
  logic [COLS-1:0] land_d [ROWS];
  logic            land_rise, clear_rise, scan_hit, hit;
  logic [3:0]      hit_row;
`ifdef LINE_COUNT_EN
  logic [7:0]      lines_q;
  assign bus.lines_cleared = lines_q;
`else
  assign bus.lines_cleared = '0;
`endif
  assign land_rise  = bus.start_land & ~land_prev_q;
  assign clear_rise = bus.start_clear & ~clear_prev_q;
  assign scan_hit   = &board_q[scan_q];
  assign hit        = found_q | scan_hit;
  assign hit_row    = found_q ? found_row_q : scan_q;
  // Piece rows placed onto board rows; shifting past column COLS-1 truncates, so cells never wrap.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      land_d[i] = '0;
      for (int r = 0; r < 4; r++)
        if ({1'b0, bus.piece_y} + 5'(r) == 5'(i))
          land_d[i] = COLS'((COLS+3)'(bus.piece_mask[4*r +: 4]) << bus.piece_x);
    end
  end
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_q      <= IDLE;
      land_prev_q  <= 1'b0;
      clear_prev_q <= 1'b0;
      clearing_q   <= 1'b0;
      found_q      <= 1'b0;
      land_done_q  <= 1'b0;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
      which_row_q  <= NONE;
      scan_q       <= '0;
      k_q          <= '0;
      found_row_q  <= '0;
      rd_data_q    <= '0;
      for (int i = 0; i < ROWS; i++) board_q[i] <= '0;
`ifdef LINE_COUNT_EN
      lines_q      <= '0;
`endif
    end else begin
      land_prev_q  <= bus.start_land;
      clear_prev_q <= bus.start_clear;
      rd_data_q    <= (bus.rd_row < 4'(ROWS)) ? board_q[bus.rd_row] : '0;
      land_done_q  <= 1'b0;
      clear_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (land_rise) begin
            state_q    <= MERGE;
            busy_q     <= 1'b1;
            clearing_q <= 1'b0;
          end else if (clear_rise) begin
            busy_q     <= 1'b1;
            clearing_q <= 1'b1;
            k_q        <= which_row_q;
            state_q    <= (which_row_q == NONE) ? CDONE : SHIFT;
            clear_done_q <= (which_row_q == NONE);
          end
        end
        MERGE: begin
          for (int i = 0; i < ROWS; i++) board_q[i] <= board_q[i] | land_d[i];
          game_over_q <= game_over_q | (|land_d[0]);
          state_q     <= SCAN;
          scan_q      <= 4'(ROWS - 1);
          found_q     <= 1'b0;
        end
        SCAN: begin
          // Scan runs bottom-up, so the first hit latched is the bottom-most full row.
          if (!found_q && scan_hit) begin
            found_q     <= 1'b1;
            found_row_q <= scan_q;
          end
          if (scan_q != '0) scan_q <= scan_q - 4'd1;
          else if (!clearing_q) begin
            state_q     <= LDONE;
            land_done_q <= 1'b1;
            which_row_q <= hit ? hit_row : NONE;
          end else if (hit) begin
            state_q <= SHIFT;
            k_q     <= hit_row;
          end else begin
            state_q      <= CDONE;
            clear_done_q <= 1'b1;
            which_row_q  <= NONE;
          end
        end
        SHIFT: begin
          if (k_q == '0) begin
            board_q[0] <= '0;
            state_q    <= SCAN;
            scan_q     <= 4'(ROWS - 1);
            found_q    <= 1'b0;
`ifdef LINE_COUNT_EN
            if (lines_q != 8'hFF) lines_q <= lines_q + 8'd1;
`endif
          end else begin
            board_q[k_q] <= board_q[k_q - 4'd1];
            k_q          <= k_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.which_row  = which_row_q;
  assign bus.land_done  = land_done_q;
  assign bus.clear_done = clear_done_q;
  assign bus.busy       = busy_q;
  assign bus.game_over  = game_over_q;
  assign bus.rd_data    = rd_data_q;
endmodule

// File: tb/tb_land_clear_unit.sv
// tb_land_clear_unit: scoreboard bench with a row-list board model for land_clear_unit.
module tb_land_clear_unit;
  localparam int ROWS = 11;
  localparam int COLS = 8;
  localparam int NONE = 11;
  localparam int FULL = (1 << COLS) - 1;
  logic clk = 1'b0;
  logic restart = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   done_cnt = 0;
  typedef struct {
    bit clr;
    int which;
    int due;
    bit go;
    int lines;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  int   mb [ROWS];
  int   mw = NONE;
  bit   mgo = 0;
  int   mlines = 0;
  land_clear_unit_if #(.COLS(COLS)) bus ();
  land_clear_unit #(.ROWS(ROWS), .COLS(COLS)) dut (.clka(clk), .restart(restart), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  function automatic int lines_exp();
`ifdef LINE_COUNT_EN
    return mlines;
`else
    return 0;
`endif
  endfunction
  function automatic int bottom_full();
    for (int i = ROWS - 1; i >= 0; i--) if (mb[i] == FULL) return i;
    return -1;
  endfunction
  task automatic model_land(input logic [15:0] m, input int x, input int y);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m[4*r+c] && y + r < ROWS && x + c < COLS) begin
          mb[y+r] |= 1 << (x + c);
          if (y + r == 0) mgo = 1;
        end
    mw = bottom_full() < 0 ? NONE : bottom_full();
  endtask
  // Returns cycles from the launch edge to the edge that raises clear_done.
  task automatic model_clear(output int d);
    int f;
    d = 0;
    if (mw != NONE) begin
      f = bottom_full();
      while (f >= 0) begin
        d += f + 1 + ROWS;
        for (int j = f; j > 0; j--) mb[j] = mb[j-1];
        mb[0] = 0;
        if (mlines < 255) mlines++;
        f = bottom_full();
      end
    end
    mw = NONE;
  endtask
  always @(negedge clk) begin
    if (!restart && (bus.land_done || bus.clear_done)) begin
      done_cnt++;
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e_m = q.pop_front();
        chk("done_kind", int'(bus.clear_done), int'(e_m.clr));
        chk("which_row", int'(bus.which_row), e_m.which);
        chk("done_cycle", cyc, e_m.due);
        chk("busy_at_done", int'(bus.busy), 1);
        chk("game_over", int'(bus.game_over), int'(e_m.go));
        chk("lines_cleared", int'(bus.lines_cleared), e_m.lines);
      end
    end
  end
  task automatic wait_done(input int tgt);
    int i;
    for (i = 0; i < 400 && done_cnt < tgt; i++) @(posedge clk);
    if (done_cnt < tgt) chk("done_timeout", done_cnt, tgt);
  endtask
  task automatic end_op();
    @(negedge clk);
    bus.start_land = 1'b0;
    bus.start_clear = 1'b0;
    @(negedge clk);
  endtask
  task automatic do_land(input logic [15:0] m, input int x, input int y, input bit both);
    int tgt;
    exp_t e;
    @(negedge clk);
    bus.piece_mask = m;
    bus.piece_x = 3'(x);
    bus.piece_y = 4'(y);
    bus.start_land = 1'b1;
    bus.start_clear = both;
    model_land(m, x, y);
    e.clr = 0; e.which = mw; e.due = cyc + 1 + 1 + ROWS; e.go = mgo; e.lines = lines_exp();
    tgt = done_cnt + 1;
    q.push_back(e);
    wait_done(tgt);
    end_op();
  endtask
  task automatic do_clear();
    int tgt, d;
    exp_t e;
    @(negedge clk);
    bus.start_clear = 1'b1;
    model_clear(d);
    e.clr = 1; e.which = NONE; e.due = cyc + 1 + d; e.go = mgo; e.lines = lines_exp();
    tgt = done_cnt + 1;
    q.push_back(e);
    wait_done(tgt);
    end_op();
  endtask
  task automatic check_row(input int r);
    @(negedge clk);
    bus.rd_row = 4'(r);
    @(negedge clk);
    chk($sformatf("rd_data[%0d]", r), int'(bus.rd_data), r < ROWS ? mb[r] : 0);
  endtask
  initial begin
    logic [15:0] m;
    bus.start_land = 1'b0;
    bus.start_clear = 1'b0;
    bus.piece_mask = '0;
    bus.piece_x = '0;
    bus.piece_y = '0;
    bus.rd_row = '0;
    for (int i = 0; i < ROWS; i++) mb[i] = 0;
    repeat (3) @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
    chk("rst_which_row", int'(bus.which_row), NONE);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_game_over", int'(bus.game_over), 0);
    chk("rst_land_done", int'(bus.land_done), 0);
    chk("rst_clear_done", int'(bus.clear_done), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    chk("rst_lines", int'(bus.lines_cleared), 0);
    do_land(16'h000F, 0, 10, 0);
    check_row(10);
    do_land(16'h000F, 4, 10, 0);
    do_clear();
    check_row(10);
    check_row(9);
    do_land(16'h00FF, 0, 9, 0);
    do_land(16'h00FF, 4, 9, 0);
    do_clear();
    check_row(0);
    check_row(1);
    check_row(10);
    do_land(16'h0033, 7, 9, 0);
    check_row(9);
    check_row(10);
    do_clear();
    do_land(16'h0001, 2, 0, 0);
    do_land(16'h0001, 5, 3, 1);
    check_row(0);
    check_row(13);
    @(negedge clk);
    bus.piece_mask = 16'h000F;
    bus.piece_x = 3'd0;
    bus.piece_y = 4'd5;
    bus.start_land = 1'b1;
    repeat (5) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    bus.start_land = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_which_row", int'(bus.which_row), NONE);
    chk("abort_game_over", int'(bus.game_over), 0);
    chk("abort_lines", int'(bus.lines_cleared), 0);
    @(negedge clk);
    restart = 1'b0;
    for (int i = 0; i < ROWS; i++) mb[i] = 0;
    mw = NONE; mgo = 0; mlines = 0;
    repeat (20) @(negedge clk);
    check_row(5);
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: m = 16'($urandom);
        1: m = 16'h000F;
        2: m = 16'h00FF;
        default: m = 16'h0F0F;
      endcase
      if ($urandom_range(0, 2) == 0) do_clear();
      else do_land(m, $urandom_range(0, 7), $urandom_range(0, 12), $urandom_range(0, 7) == 0);
      check_row($urandom_range(0, 15));
    end
    do_clear();
    for (int i = 0; i < ROWS; i++) check_row(i);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
